// File: rtl/sigmoid_backprop_16_bit.sv
// Sigmoid backward pass: dx = dy * y * (1 - y) in signed fixed point.
// One shared fixed-point multiplier is time-multiplexed over two cycles.
// Valid/ready handshake on both the operand and the result side.
module sigmoid_backprop_16_bit #(
    parameter int unsigned N = 16,
    parameter int unsigned Q = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] y_in,
    input  logic [N-1:0] dy_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] dx_out
);

    localparam int unsigned PW = 2 * N;

    // 1.0 in Q format, plus the saturation limits of an N-bit signed word
    localparam logic signed [N-1:0] ONE   = N'(32'd1 << Q);
    localparam logic signed [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL1 = 2'd1;
    localparam logic [1:0] S_MUL2 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_next;

    logic signed [N-1:0]  y_reg;
    logic signed [N-1:0]  dy_reg;
    logic signed [N-1:0]  t_reg;

    logic signed [N-1:0]  y_clamp_c;
    logic signed [N-1:0]  mul_a_c;
    logic signed [N-1:0]  mul_b_c;
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] shifted_c;
    logic signed [N-1:0]  mul_res_c;

    logic                 accept_c;
    logic                 retire_c;

    assign accept_c = (state == S_IDLE) && in_valid;
    assign retire_c = (state == S_DONE) && out_ready;

    // Clamp the incoming activation into the legal sigmoid range [0, 1.0]
    always_comb begin
        y_clamp_c = $signed(y_in);
        if (y_in[N-1]) begin
            y_clamp_c = '0;
        end else if ($signed(y_in) > ONE) begin
            y_clamp_c = ONE;
        end
    end

    // Operand select for the shared multiplier: y*(1-y) first, then t*dy
    always_comb begin
        mul_a_c = '0;
        mul_b_c = '0;
        case (state)
            S_MUL1: begin
                mul_a_c = y_reg;
                mul_b_c = ONE - y_reg;
            end
            S_MUL2: begin
                mul_a_c = t_reg;
                mul_b_c = dy_reg;
            end
            default: begin
                mul_a_c = '0;
                mul_b_c = '0;
            end
        endcase
    end

    // Full-width signed product, rescaled by floor (arithmetic shift)
    assign prod_c    = PW'(mul_a_c) * PW'(mul_b_c);
    assign shifted_c = prod_c >>> Q;

    // Saturate when the bits above the result sign are not a pure sign extension
    always_comb begin
        mul_res_c = shifted_c[N-1:0];
        if ((shifted_c[PW-1:N-1] != '0) && (shifted_c[PW-1:N-1] != '1)) begin
            mul_res_c = shifted_c[PW-1] ? S_MIN : S_MAX;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed IDLE -> MUL1 -> MUL2 -> DONE sequence
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid)  state_next = S_MUL1;
            S_MUL1:                state_next = S_MUL2;
            S_MUL2:                state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default:               state_next = S_IDLE;
        endcase
    end

    // Operand capture and intermediate product
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_reg  <= '0;
            dy_reg <= '0;
            t_reg  <= '0;
        end else begin
            if (accept_c) begin
                y_reg  <= y_clamp_c;
                dy_reg <= $signed(dy_in);
            end
            if (state == S_MUL1) begin
                t_reg <= mul_res_c;
            end
        end
    end

    // Result register; holds its value until the next MUL2 overwrites it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dx_out <= '0;
        end else if (state == S_MUL2) begin
            dx_out <= mul_res_c;
        end
    end

    // Handshake flags registered from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == S_IDLE);
            out_valid <= (state_next == S_DONE);
        end
    end

    // retire_c documents the DONE exit condition used by the next-state logic
    logic unused_c;
    assign unused_c = retire_c;

endmodule
